data_mem_master: RTL
====================

DATA_MEM_MASTER -- requirements
Module: data_mem_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of request and memory ports.
REQ-002 Parameter NB_COL, default 4, byte lanes per memory word.
REQ-003 Parameter COL_WIDTH, default 8, bits per lane; data width DW = NB_COL*COL_WIDTH (32).
REQ-004 The block SHALL use a single clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  high exactly when state is IDLE.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-012 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-013 req_wdata  input  DW  store data, right-aligned.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  response consumed.
REQ-016 rsp_rdata  output  DW  aligned and extended load data; 0 for stores and errors.
REQ-017 rsp_err  output  1  misaligned or illegal-size request.
REQ-018 mem_we  output  NB_COL  per-lane write enable to the byte-write RAM.
REQ-019 mem_addr  output  ADDR_WIDTH  word-aligned byte address {req_addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-020 mem_di  output  DW  lane-replicated store data.
REQ-021 mem_dout  input  DW  RAM read data, valid one cycle after the address is presented.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, RDATA, RESP; one outstanding request; no pipelining.
REQ-023 IDLE: on req_valid, latch request; illegal -> RESP with rsp_err=1 and no memory access; legal -> ACCESS.
REQ-024 Illegal: size 11; half with addr[0]=1; word with addr[1:0]!=00.
REQ-025 mem_addr and mem_di SHALL be registered on accept and held until the next accept.
REQ-026 ACCESS: mem_we = lane mask for stores, 0 for loads; next state RESP for stores, RDATA for loads.
REQ-027 Lane mask: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-028 mem_di: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 mem_we SHALL be 0 in every state other than ACCESS.
REQ-030 RDATA: capture mem_dout >> (8*addr[1:0]), truncate to size, extend per req_unsigned into rsp_rdata; then RESP.
REQ-031 RESP: rsp_valid=1; hold rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then IDLE.
REQ-032 rsp_ready=1 at RESP entry SHALL complete the response in that cycle.
REQ-033 Latency accept-edge to rsp_valid: error 1 cycle, store 2, load 3.
REQ-034 rsp_err and rsp_rdata SHALL be cleared to 0 when a new request is accepted.

Reset
REQ-035 On rst: state IDLE, mem_we=0, mem_addr=0, mem_di=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1.
REQ-036 rst mid-operation SHALL abort immediately: mem_we drops asynchronously; no response is issued for the aborted request.

Verification
REQ-037 Store byte 0xA5 to 0x13 -> ACCESS cycle: mem_we=1000, mem_addr=0x10, mem_di=0xA5A5A5A5; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-038 RAM word 0x80F0_1234 at 0x20; signed half load from 0x22 -> rsp_rdata=0xFFFF80F0; unsigned -> 0x000080F0; signed byte at 0x21 -> 0x00000012.
REQ-039 Word load from 0x06 -> rsp_err=1 one cycle after accept, mem_we never nonzero, rsp_rdata=0; size 11 -> same.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable, req_ready=0; release -> IDLE next cycle.
REQ-041 Assert rst during ACCESS of a word store to 0x40 -> mem_we=0 immediately, RAM word at 0x40 unchanged, no rsp_valid.
REQ-042 Back-to-back store word 0xDEADBEEF to 0x30, then load word from 0x30 -> load returns 0xDEADBEEF.

Source files
------------

// File: rtl/data_mem_master.sv
// Load/store master for a byte-write RAM with a synchronous read port.
// It accepts one request at a time, aligns and extends load data, and flags misaligned or illegal requests.
module data_mem_master #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int NB_COL     = 4,
  parameter  int COL_WIDTH  = 8,
  localparam int DW         = NB_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DW-1:0]         req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [NB_COL-1:0]     mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DW-1:0]         mem_di,
  input  logic [DW-1:0]         mem_dout
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | address/data on the RAM port, write lanes enabled for stores
  // RDATA  | RAM read data valid, captured into rsp_rdata
  // RESP   | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              illegal;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [NB_COL-1:0] mask_d;
  logic [NB_COL-1:0] mask_q;
  logic [DW-1:0]     di_d;
  logic [DW-1:0]     shifted;
  logic [DW-1:0]     load_val;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    illegal = 1'b0;
    case (req_size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = req_addr[0];
      2'b10:   illegal = |req_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    mask_d = '0;
    di_d   = req_wdata;
    case (req_size)
      2'b00: begin
        mask_d = NB_COL'(1) << req_addr[1:0];
        di_d   = {NB_COL{req_wdata[COL_WIDTH-1:0]}};
      end
      2'b01: begin
        mask_d = NB_COL'(3) << req_addr[1:0];
        di_d   = {(NB_COL/2){req_wdata[2*COL_WIDTH-1:0]}};
      end
      2'b10: begin
        mask_d = '1;
        di_d   = req_wdata;
      end
      default: begin
        mask_d = '0;
        di_d   = req_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then truncate and extend to the access size.
  always_comb begin
    shifted  = mem_dout >> (COL_WIDTH * int'(off_q));
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = {{(DW-COL_WIDTH){~uns_q & shifted[COL_WIDTH-1]}},
                           shifted[COL_WIDTH-1:0]};
      2'b01:   load_val = {{(DW-2*COL_WIDTH){~uns_q & shifted[2*COL_WIDTH-1]}},
                           shifted[2*COL_WIDTH-1:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = illegal ? RESP : ACCESS;
      ACCESS:  state_nxt = we_q ? RESP : RDATA;
      RDATA:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from state so that an asynchronous reset drops the write enables at once.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = '0;
    case (state)
      IDLE:    req_ready = 1'b1;
      ACCESS:  mem_we    = we_q ? mask_q : '0;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      mask_q    <= '0;
      mem_addr  <= '0;
      mem_di    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      we_q      <= req_we;
      uns_q     <= req_unsigned;
      size_q    <= req_size;
      off_q     <= req_addr[1:0];
      mask_q    <= mask_d;
      mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_di    <= di_d;
      rsp_rdata <= '0;
      rsp_err   <= illegal;
    end else if (state == RDATA) begin
      rsp_rdata <= load_val;
    end
  end

endmodule
